// File: rtl/product_half_splitter.sv
// Product half splitter: captures a 2*BLOCKS product stream, then emits the
// lower half paired with a stored constant and the upper half alongside.
module product_half_splitter #(
  parameter int REGISTER_SIZE = 32,
  parameter int BITS_IN_NUM   = 4096
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic [REGISTER_SIZE-1:0] const_in,
  input  logic                     const_valid_in,
  input  logic [REGISTER_SIZE-1:0] data_in,
  input  logic                     valid_in,
  input  logic                     final_in,
  input  logic                     ready_in,
  output logic [REGISTER_SIZE-1:0] n_out,
  output logic [REGISTER_SIZE-1:0] m_out,
  output logic                     pair_valid_out,
  output logic [REGISTER_SIZE-1:0] hi_out,
  output logic                     last_out,
  output logic                     ready_out,
  output logic                     const_loaded_out,
  output logic                     error_out
);

  localparam int BLOCKS = BITS_IN_NUM / REGISTER_SIZE;
  localparam int CW     = $clog2(BLOCKS);
  localparam int AW     = CW + 1;
  localparam int NW     = AW + 1;
  localparam logic [NW-1:0] FULL  = NW'(2 * BLOCKS);
  localparam logic [CW-1:0] LASTC = CW'(BLOCKS - 1);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    WAIT_READY,
    EMIT
  } state_e;

  logic [REGISTER_SIZE-1:0] prod_mem [2*BLOCKS];
  logic [REGISTER_SIZE-1:0] const_mem [BLOCKS];

  state_e state_q, state_d;
  logic [NW-1:0] cap_q, cap_d;
  logic [CW-1:0] rd_q, rd_d;
  logic [CW-1:0] cw_q, cw_d;
  logic iss_q, iss_d;
  logic loaded_q, loaded_d;
  logic err_q, err_d;
  logic rdy_q, rdy_d;

  logic prod_we;
  logic [AW-1:0] prod_wa;
  logic const_we;
  logic s1_v_d;

  logic s1_v_q, s1_last_q;
  logic [REGISTER_SIZE-1:0] s1_n_q, s1_h_q, s1_m_q;
  logic pv_q, last_q;
  logic [REGISTER_SIZE-1:0] n_q, m_q, h_q;

  // Control FSM: constant load, capture counting, read issue
  always_comb begin
    state_d  = state_q;
    cap_d    = cap_q;
    rd_d     = rd_q;
    cw_d     = cw_q;
    iss_d    = iss_q;
    loaded_d = loaded_q;
    err_d    = err_q;
    prod_we  = 1'b0;
    prod_wa  = cap_q[AW-1:0];
    const_we = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (const_valid_in) begin
          const_we = 1'b1;
          if (cw_q == LASTC) begin
            cw_d     = '0;
            loaded_d = 1'b1;
          end else begin
            cw_d = cw_q + 1'b1;
          end
        end
        if (valid_in && rdy_q) begin
          prod_we = 1'b1;
          prod_wa = '0;
          cap_d   = NW'(1);
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (valid_in && (cap_q < FULL)) begin
          prod_we = 1'b1;
          cap_d   = cap_q + 1'b1;
        end
        if (final_in) begin
          if (cap_d == FULL) begin
            state_d = WAIT_READY;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      WAIT_READY: begin
        if (ready_in) begin
          state_d = EMIT;
          rd_d    = '0;
          iss_d   = 1'b1;
        end
      end
      EMIT: begin
        if (iss_q) begin
          rd_d = rd_q + 1'b1;
          if (rd_q == LASTC) iss_d = 1'b0;
        end
        if (last_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    rdy_d  = (state_d == IDLE) && loaded_d;
    s1_v_d = (state_q == EMIT) && iss_q;
  end

  // Control state registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= IDLE;
      cap_q    <= '0;
      rd_q     <= '0;
      cw_q     <= '0;
      iss_q    <= 1'b0;
      loaded_q <= 1'b0;
      err_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cap_q    <= cap_d;
      rd_q     <= rd_d;
      cw_q     <= cw_d;
      iss_q    <= iss_d;
      loaded_q <= loaded_d;
      err_q    <= err_d;
      rdy_q    <= rdy_d;
    end
  end

  // Buffer writes; contents need no reset
  always_ff @(posedge clk_in) begin
    if (prod_we) prod_mem[prod_wa] <= data_in;
    if (const_we) const_mem[cw_q] <= const_in;
  end

  // Two-stage read pipeline: buffer fetch, then output register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s1_v_q    <= 1'b0;
      s1_last_q <= 1'b0;
      s1_n_q    <= '0;
      s1_h_q    <= '0;
      s1_m_q    <= '0;
      pv_q      <= 1'b0;
      last_q    <= 1'b0;
      n_q       <= '0;
      m_q       <= '0;
      h_q       <= '0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_last_q <= s1_v_d && (rd_q == LASTC);
      if (s1_v_d) begin
        s1_n_q <= prod_mem[{1'b0, rd_q}];
        s1_h_q <= prod_mem[{1'b1, rd_q}];
        s1_m_q <= const_mem[rd_q];
      end
      pv_q   <= s1_v_q;
      last_q <= s1_last_q;
      if (s1_v_q) begin
        n_q <= s1_n_q;
        m_q <= s1_m_q;
        h_q <= s1_h_q;
      end
    end
  end

  assign n_out            = n_q;
  assign m_out            = m_q;
  assign hi_out           = h_q;
  assign pair_valid_out   = pv_q;
  assign last_out         = last_q;
  assign ready_out        = rdy_q;
  assign const_loaded_out = loaded_q;
  assign error_out        = err_q;

endmodule

// File: tb/tb_product_half_splitter.sv
// Directed bench for product_half_splitter with BLOCKS=4.
// Expected values are hand-derived from the stimulus tables.
module tb_product_half_splitter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] const_in;
  logic        const_valid_in;
  logic [31:0] data_in;
  logic        valid_in;
  logic        final_in;
  logic        ready_in;
  logic [31:0] n_out, m_out, hi_out;
  logic        pair_valid_out, last_out;
  logic        ready_out, const_loaded_out, error_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  product_half_splitter #(
    .REGISTER_SIZE(32),
    .BITS_IN_NUM  (128)
  ) dut (
    .clk_in          (clk),
    .rst_n_in        (rst_n),
    .const_in        (const_in),
    .const_valid_in  (const_valid_in),
    .data_in         (data_in),
    .valid_in        (valid_in),
    .final_in        (final_in),
    .ready_in        (ready_in),
    .n_out           (n_out),
    .m_out           (m_out),
    .pair_valid_out  (pair_valid_out),
    .hi_out          (hi_out),
    .last_out        (last_out),
    .ready_out       (ready_out),
    .const_loaded_out(const_loaded_out),
    .error_out       (error_out)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_n"}, n_out, 0);
    chk({tag, "_m"}, m_out, 0);
    chk({tag, "_hi"}, hi_out, 0);
    chk({tag, "_pv"}, {31'b0, pair_valid_out}, 0);
    chk({tag, "_last"}, {31'b0, last_out}, 0);
    chk({tag, "_rdy"}, {31'b0, ready_out}, 0);
    chk({tag, "_cl"}, {31'b0, const_loaded_out}, 0);
    chk({tag, "_err"}, {31'b0, error_out}, 0);
  endtask

  // n beats base..base+n-1, then rep copies of the last beat; final on the
  // very last beat. A stray constant beat is driven mid-capture.
  task automatic send_prod(input int n, input logic [31:0] base,
                           input int rep);
    for (int i = 0; i < n; i++) begin
      valid_in       = 1'b1;
      data_in        = base + 32'(i);
      const_valid_in = (i == 2);
      const_in       = 32'hDEAD_BEEF;
      final_in       = (rep == 0) && (i == n - 1);
      step;
      const_valid_in = 1'b0;
      if (i == 0) chk("rdy_drop", {31'b0, ready_out}, 0);
    end
    for (int r = 0; r < rep; r++) begin
      data_in  = base + 32'(n - 1);
      final_in = (r == rep - 1);
      step;
    end
    valid_in = 1'b0;
    final_in = 1'b0;
  endtask

  // Holds ready_in low for wait_n cycles, then pulses it and checks beats.
  task automatic emit(input int wait_n, input logic [31:0] base);
    for (int w = 0; w < wait_n; w++) begin
      step;
      chk("bp_pv", {31'b0, pair_valid_out}, 0);
    end
    ready_in = 1'b1;
    step;
    ready_in = 1'b0;
    chk("lat_t0_pv", {31'b0, pair_valid_out}, 0);
    step;
    chk("lat_t1_pv", {31'b0, pair_valid_out}, 0);
    step;
    for (int k = 0; k < 4; k++) begin
      chk("beat_pv", {31'b0, pair_valid_out}, 1);
      chk("beat_n", n_out, base + 32'(k));
      chk("beat_hi", hi_out, base + 32'(k + 4));
      chk("beat_m", m_out, 32'hC0 + 32'(k));
      chk("beat_last", {31'b0, last_out}, {31'b0, (k == 3)});
      chk("beat_rdy", {31'b0, ready_out}, 0);
      if (k < 3) step;
    end
    step;
    chk("post_pv", {31'b0, pair_valid_out}, 0);
    chk("post_rdy", {31'b0, ready_out}, 1);
  endtask

  task automatic load_const;
    for (int i = 0; i < 4; i++) begin
      const_valid_in = 1'b1;
      const_in       = 32'hC0 + 32'(i);
      step;
      chk("cl_prog", {31'b0, const_loaded_out}, {31'b0, (i == 3)});
    end
    const_valid_in = 1'b0;
    chk("cl_rdy", {31'b0, ready_out}, 1);
  endtask

  initial begin
    rst_n          = 1'b0;
    const_in       = '0;
    const_valid_in = 1'b0;
    data_in        = '0;
    valid_in       = 1'b0;
    final_in       = 1'b0;
    ready_in       = 1'b0;
    step;
    step;
    chk_all_zero("rst");
    rst_n = 1'b1;
    step;

    // valid_in before any constant is ignored
    valid_in = 1'b1;
    data_in  = 32'h55;
    step;
    step;
    valid_in = 1'b0;
    chk("nr_rdy", {31'b0, ready_out}, 0);
    chk("nr_cl", {31'b0, const_loaded_out}, 0);

    load_const;

    // nominal split with tail beats, immediate ready
    send_prod(8, 32'h00, 3);
    emit(0, 32'h00);

    // backpressure: ready_in held low 10 cycles
    send_prod(8, 32'h20, 0);
    emit(10, 32'h20);
    chk("err_clean", {31'b0, error_out}, 0);

    // short product
    send_prod(5, 32'h40, 0);
    chk("short_err", {31'b0, error_out}, 1);
    chk("short_rdy", {31'b0, ready_out}, 1);
    ready_in = 1'b1;
    for (int w = 0; w < 4; w++) begin
      step;
      chk("short_pv", {31'b0, pair_valid_out}, 0);
    end
    ready_in = 1'b0;
    send_prod(8, 32'h10, 0);
    emit(2, 32'h10);
    chk("err_sticky", {31'b0, error_out}, 1);

    // reset mid-emit after two beats
    send_prod(8, 32'h60, 0);
    ready_in = 1'b1;
    step;
    ready_in = 1'b0;
    step;
    step;
    chk("mid_b0", n_out, 32'h60);
    step;
    chk("mid_b1", n_out, 32'h61);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    step;
    rst_n = 1'b1;
    step;
    chk("mid_post_rdy", {31'b0, ready_out}, 0);
    chk("mid_post_cl", {31'b0, const_loaded_out}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/product_half_splitter.md
# product_half_splitter

Sits directly downstream of the non-parallel block multiplier in the Montgomery datapath. It captures the multiplier's 2·BITS_IN_NUM-bit product stream and splits it into two halves. The lower half goes back out paired block-by-block with a preloaded constant (N′), as a gap-free operand stream for the next multiplication. The upper half is forwarded on a separate stream in the same cycles.

## Interface
- REGISTER_SIZE, 32: block width in bits.
- BITS_IN_NUM, 4096: operand width; BLOCKS = BITS_IN_NUM/REGISTER_SIZE (128), product is 2·BLOCKS blocks.
- clk_in  input  1  sole clock; all state on rising edge.
- rst_n_in  input  1  reset is asynchronous and active-low.
- const_in  input  REGISTER_SIZE  constant block, LS block first.
- const_valid_in  input  1  const_in beat valid; honoured only in IDLE.
- data_in  input  REGISTER_SIZE  product block, LS block first (multiplier data_out).
- valid_in  input  1  data_in beat valid (multiplier valid_out).
- final_in  input  1  end-of-product strobe (multiplier final_out).
- ready_in  input  1  downstream multiplier idle/ready.
- n_out  output  REGISTER_SIZE  lower-half product block.
- m_out  output  REGISTER_SIZE  constant block at the same index.
- pair_valid_out  output  1  n_out/m_out beat valid.
- hi_out  output  REGISTER_SIZE  upper-half product block at the same index.
- last_out  output  1  high on the final (index BLOCKS-1) beat.
- ready_out  output  1  block can accept a product stream.
- const_loaded_out  output  1  full constant stored.
- error_out  output  1  sticky short-product error; cleared only by reset.

## Operation
- Storage: product buffer, 2·BLOCKS deep; constant buffer, BLOCKS deep.
- Constant load:
  - In IDLE, each const_valid_in beat writes const_in at the const write index, then the index increments.
  - After BLOCKS beats: const_loaded_out=1 and the index wraps to 0.
  - Further beats overwrite from index 0; const_loaded_out stays 1.
- States: IDLE, CAPTURE, WAIT_READY, EMIT.
- IDLE:
  - ready_out = const_loaded_out.
  - A valid_in while ready_out=1 writes index 0 and moves to CAPTURE.
  - valid_in while ready_out=0 is ignored.
- CAPTURE:
  - Each valid_in beat writes data_in at the capture index, which increments.
  - Beats after index 2·BLOCKS-1 are discarded. These are the multiplier's repeated tail beats while its final strobe pipes through.
  - final_in with the count complete (2·BLOCKS beats) moves to WAIT_READY.
  - final_in with the count short sets error_out, discards the product and returns to IDLE.
  - const_valid_in is ignored.
- WAIT_READY: ready_in sampled high moves to EMIT.
- EMIT: beats k = 0..BLOCKS-1 carry:
  - n_out = product[k];
  - hi_out = product[BLOCKS+k];
  - m_out = const[k].
- After the last beat: return to IDLE. The constant is retained.
- Emission is not throttled. ready_in is ignored once EMIT is entered, because the downstream multiplier cannot stall its WRITING phase.
- No arithmetic is performed; data bits pass through unchanged.

## Timing
- Reset (rst_n_in low, asynchronous):
  - State IDLE, all indices 0.
  - All outputs 0: n_out, m_out, hi_out, pair_valid_out, last_out, ready_out, const_loaded_out, error_out.
  - Buffer contents are don't-care.
- Reset mid-CAPTURE or mid-EMIT aborts immediately. After release the block needs a fresh constant load.
- Capture latency: a beat is written in the cycle it is presented; no input backpressure.
- Emit latency: ready_in sampled high at edge T → first pair_valid_out beat registered at edge T+2. The 2-cycle read prefetch is fixed.
- pair_valid_out is then high for exactly BLOCKS consecutive cycles.
- last_out coincides with the last beat.
- ready_out drops at the edge that accepts the first capture beat and stays low until the edge after last_out.
- Simultaneous events:
  - valid_in and final_in in the same cycle: the beat is written first, then the count is checked.
  - const_valid_in during CAPTURE/EMIT: dropped.
- Outputs are registered. n_out, m_out and hi_out hold their last values when pair_valid_out=0; benches must check them only when valid.

## Test plan
Benches use BITS_IN_NUM=128 (BLOCKS=4).
- Reset/constant load:
  - Reset: all outputs 0.
  - Load constants 0xC0..0xC3: const_loaded_out=1 after the 4th beat; ready_out=1.
- Nominal split:
  - Product 0x00..0x07, then 3 repeated 0x07 beats, final_in, ready_in=1.
  - Required: 4 beats from T+2 with (n,m,hi) = (0x00,0xC0,0x04)…(0x03,0xC3,0x07); last_out on beat 4; ready_out reasserts.
- Backpressure: hold ready_in=0 for 10 cycles after final_in → no beats; emission starts 2 cycles after ready_in rises.
- Short product: 5 beats then final_in → error_out=1, no emission, ready_out=1; next full product splits correctly.
- Not ready: valid_in before any constant load → ignored; ready_out stays 0.
- Reset mid-EMIT after beat 2 → outputs 0 immediately; const_loaded_out=0.
